mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit for the RV32I-subset CPU. A Moore-style state machine that sequences the fetch stage (IR/PC write enables), operand latches, ALU, register file and data memory, one instruction at a time. It sits beside the datapath and takes decoded fields (opcode, func3, func7) plus the ALU zero flag. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  allows a new fetch from IDLE. Sampled in IDLE only.
- opcode  in  7  decoded IR[6:0].
- func3  in  3  decoded IR[14:12].
- func7  in  7  decoded IR[31:25].
- zero  in  1  ALU zero flag. Used only in BRANCH.
- IR_Write  out  1  load the instruction register.
- PC_Write  out  1  load the PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jal target.
- AB_Write  out  1  latch rs1/rs2 register data into operand registers A/B.
- alu_op  out  4  ALU operation code.
- alu_src_b  out  1  ALU B source: 0 = B register, 1 = immediate.
- F_Write  out  1  latch the ALU result into the F register.
- Reg_Write  out  1  register-file write enable.
- wb_sel  out  2  write-back source: 0 = F, 1 = memory data, 2 = PC (link), 3 = immediate.
- Mem_Read  out  1  data-memory read strobe.
- Mem_Write  out  1  data-memory write strobe.
- illegal  out  1  sticky trap flag.
- state  out  4  current state, for debug.
- instret  out  32  count of retired instructions.

## Operation
- State encoding (4 bits): IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, WB_ALU 5, MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9, BRANCH 10, JAL_WB 11, LUI_WB 12, TRAP 15.
- IDLE
  - run=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH: IR_Write=1, PC_Write=1, pc_src=0. Then → DECODE.
- DECODE: AB_Write=1. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 → MEM_ADDR
  - 0100011 → MEM_ADDR
  - 1100011 → BRANCH, only when func3 is 000 or 001; any other func3 → TRAP
  - 1101111 → JAL_WB
  - 0110111 → LUI_WB
  - any other opcode → TRAP
- EXEC_R: F_Write=1, alu_src_b=0, alu_op={func7[5],func3}. Then → WB_ALU.
- EXEC_I: F_Write=1, alu_src_b=1.
  - alu_op={func7[5],func3} when func3=101.
  - Otherwise alu_op={1'b0,func3}.
  - Then → WB_ALU.
- WB_ALU: Reg_Write=1, wb_sel=0. Retire. Then → FETCH if run=1, else IDLE.
- MEM_ADDR: alu_op=ADD, alu_src_b=1, F_Write=1.
  - Load (opcode 0000011) → MEM_RD.
  - Store → MEM_WR.
- MEM_RD: Mem_Read=1. Then → MEM_WB.
- MEM_WB: Reg_Write=1, wb_sel=1, Mem_Read=1. Retire.
- MEM_WR: Mem_Write=1. Retire.
- BRANCH: alu_op=SUB, alu_src_b=0.
  - Taken = (func3=000 & zero) | (func3=001 & ~zero).
  - PC_Write=taken, pc_src=1. Retire.
- JAL_WB: Reg_Write=1, wb_sel=2, PC_Write=1, pc_src=2. Retire.
- LUI_WB: Reg_Write=1, wb_sel=3. Retire.
- Retire (every retiring state):
  - instret increments by 1 and wraps at 2^32 to 0.
  - Next state is FETCH if run=1, else IDLE.
- TRAP
  - Absorbing state; only rst leaves it.
  - illegal=1; all enables are 0.
  - instret is not incremented.
- alu_op codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Any output not listed for a state is 0.

## Timing
- All enables are decoded from the registered state. The one Mealy exception is PC_Write in BRANCH, which depends combinationally on zero and func3.
- Cycles per instruction, counting FETCH:
  - R / I-ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - lui: 3
  - Add 1 IDLE cycle whenever run=0 at retire.
- Reset (asynchronous): state=IDLE, instret=0, illegal=0, all enables 0. This takes effect immediately, including mid-instruction; no partial write completes after rst asserts.
- Deasserting rst has no effect until the first rising edge on which run=1 is sampled in IDLE.
- run is ignored in every state except IDLE and the retire decision. Dropping run mid-instruction never aborts the instruction.
- opcode, func3 and func7 must be stable from DECODE through retire. They come from IR, which is written only in FETCH.

## Structure
- Shared package `cpu_pkg`:
  - state enum constants
  - alu_op localparams
  - opcode localparams
  - pc_src and wb_sel codes
- Single module with no sub-modules. It contains three parts: the state register, next-state logic, and output decode. The instret counter lives in the same always block as the state register.

## Test plan
- Reset mid-MEM_RD: assert rst → state=0, Mem_Read=0, instret=0 within the same cycle; after release with run=1, FETCH appears on the next edge.
- R-type ADD (0110011, f3=000, f7=0000000), run=1: state sequence 1,2,3,5,1; alu_op=0000 in EXEC_R; Reg_Write=1 for exactly one cycle; instret=1.
- SUB/SRAI: R f7=0100000, f3=000 → alu_op=1000. I-type f3=101, f7=0100000 → 1101. I-type f3=000 with f7[5]=1 → 0000.
- BEQ, BNE and JAL:
  - BEQ with zero=1 → PC_Write=1, pc_src=1 in BRANCH.
  - BNE with zero=1 → PC_Write=0.
  - JAL → Reg_Write=1, wb_sel=2, pc_src=2.
  - Each takes 3 cycles.
- Load then store with run held 1: 5+4 cycles; Mem_Read high 2 cycles, Mem_Write high 1 cycle; instret=2.
- Illegal instructions: opcode 1110011 → TRAP (state=15), illegal=1, no enables; instret frozen through 10 cycles of run=1. Branch with func3=100 → TRAP as well.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode, ALU and mux-select codes for the RV32I-subset CPU
package cpu_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_ALU   = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL_WB   = 4'd11,
      S_LUI_WB   = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;
   localparam logic [2:0] F3_SRLA  = 3'b101;

   localparam logic [1:0] PC_SRC_PC4 = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JAL = 2'd2;

   localparam logic [1:0] WB_F   = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle control FSM with retired-instruction counter
module mc_controller
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        zero,
   output logic        IR_Write,
   output logic        PC_Write,
   output logic [1:0]  pc_src,
   output logic        AB_Write,
   output logic [3:0]  alu_op,
   output logic        alu_src_b,
   output logic        F_Write,
   output logic        Reg_Write,
   output logic [1:0]  wb_sel,
   output logic        Mem_Read,
   output logic        Mem_Write,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] instret
);

   state_t cur_state;
   state_t next_state;
   logic   retire;

   // Only func7[5] distinguishes SUB/SRA; the other bits are don't-care here.
   logic unused_func7;
   assign unused_func7 = ^{func7[6], func7[4:0]};

   assign state = cur_state;

   // State register and retired-instruction counter; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_IDLE;
         instret   <= 32'd0;
      end else begin
         cur_state <= next_state;
         if (retire) begin
            instret <= instret + 32'd1;
         end
      end
   end

   // Next-state selection and retire detection.
   always_comb begin
      next_state = cur_state;
      retire     = 1'b0;
      case (cur_state)
         S_IDLE:     next_state = run ? S_FETCH : S_IDLE;
         S_FETCH:    next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:      next_state = S_EXEC_R;
               OP_I:      next_state = S_EXEC_I;
               OP_LOAD:   next_state = S_MEM_ADDR;
               OP_STORE:  next_state = S_MEM_ADDR;
               OP_BRANCH: next_state = (func3 == F3_BEQ || func3 == F3_BNE) ? S_BRANCH : S_TRAP;
               OP_JAL:    next_state = S_JAL_WB;
               OP_LUI:    next_state = S_LUI_WB;
               default:   next_state = S_TRAP;
            endcase
         end
         S_EXEC_R:   next_state = S_WB_ALU;
         S_EXEC_I:   next_state = S_WB_ALU;
         S_MEM_ADDR: next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   next_state = S_MEM_WB;
         S_WB_ALU, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL_WB, S_LUI_WB: begin
            retire     = 1'b1;
            next_state = run ? S_FETCH : S_IDLE;
         end
         S_TRAP:     next_state = S_TRAP;
         default:    next_state = S_TRAP;
      endcase
   end

   // Output decode from the registered state; BRANCH's PC_Write is the only input-dependent enable.
   always_comb begin
      IR_Write  = 1'b0;
      PC_Write  = 1'b0;
      pc_src    = PC_SRC_PC4;
      AB_Write  = 1'b0;
      alu_op    = ALU_ADD;
      alu_src_b = 1'b0;
      F_Write   = 1'b0;
      Reg_Write = 1'b0;
      wb_sel    = WB_F;
      Mem_Read  = 1'b0;
      Mem_Write = 1'b0;
      illegal   = 1'b0;
      case (cur_state)
         S_FETCH: begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
            pc_src   = PC_SRC_PC4;
         end
         S_DECODE:   AB_Write = 1'b1;
         S_EXEC_R: begin
            F_Write   = 1'b1;
            alu_src_b = 1'b0;
            alu_op    = {func7[5], func3};
         end
         S_EXEC_I: begin
            F_Write   = 1'b1;
            alu_src_b = 1'b1;
            // Immediate shifts carry the SRL/SRA selector in func7[5]; other I-ops have no SUB form.
            alu_op    = (func3 == F3_SRLA) ? {func7[5], func3} : {1'b0, func3};
         end
         S_WB_ALU: begin
            Reg_Write = 1'b1;
            wb_sel    = WB_F;
         end
         S_MEM_ADDR: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            F_Write   = 1'b1;
         end
         S_MEM_RD:   Mem_Read = 1'b1;
         S_MEM_WB: begin
            Reg_Write = 1'b1;
            wb_sel    = WB_MEM;
            Mem_Read  = 1'b1;
         end
         S_MEM_WR:   Mem_Write = 1'b1;
         S_BRANCH: begin
            alu_op    = ALU_SUB;
            alu_src_b = 1'b0;
            pc_src    = PC_SRC_BR;
            PC_Write  = ((func3 == F3_BEQ) & zero) | ((func3 == F3_BNE) & ~zero);
         end
         S_JAL_WB: begin
            Reg_Write = 1'b1;
            wb_sel    = WB_PC;
            PC_Write  = 1'b1;
            pc_src    = PC_SRC_JAL;
         end
         S_LUI_WB: begin
            Reg_Write = 1'b1;
            wb_sel    = WB_IMM;
         end
         S_TRAP:     illegal = 1'b1;
         default:    illegal = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        zero;
   logic        IR_Write, PC_Write, AB_Write, F_Write, Reg_Write, Mem_Read, Mem_Write;
   logic        alu_src_b, illegal;
   logic [1:0]  pc_src, wb_sel;
   logic [3:0]  alu_op, state;
   logic [31:0] instret;

   int n_checks = 0;
   int n_errors = 0;

   int          cyc, n_rw, n_mr, n_mw, n_pcw;
   logic [3:0]  aop;
   logic [1:0]  psrc, wsel;
   logic [14:0] enables;

   always #5 clk = ~clk;

   assign enables = {IR_Write, PC_Write, AB_Write, F_Write, Reg_Write, Mem_Read, Mem_Write,
                     alu_src_b, pc_src, wb_sel, alu_op};

   mc_controller dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .opcode    (opcode),
      .func3     (func3),
      .func7     (func7),
      .zero      (zero),
      .IR_Write  (IR_Write),
      .PC_Write  (PC_Write),
      .pc_src    (pc_src),
      .AB_Write  (AB_Write),
      .alu_op    (alu_op),
      .alu_src_b (alu_src_b),
      .F_Write   (F_Write),
      .Reg_Write (Reg_Write),
      .wb_sel    (wb_sel),
      .Mem_Read  (Mem_Read),
      .Mem_Write (Mem_Write),
      .illegal   (illegal),
      .state     (state),
      .instret   (instret)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting from a sampled FETCH cycle; stops at the next FETCH/IDLE/TRAP.
   task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z);
      opcode = op; func3 = f3; func7 = f7; zero = z;
      cyc = 1; n_rw = 0; n_mr = 0; n_mw = 0; n_pcw = 0;
      aop = 4'hF; psrc = 2'd0; wsel = 2'd0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (state == 4'd1 || state == 4'd0 || state == 4'd15) break;
         cyc++;
         n_rw  += int'(Reg_Write);
         n_mr  += int'(Mem_Read);
         n_mw  += int'(Mem_Write);
         n_pcw += int'(PC_Write);
         if (F_Write || state == 4'd10) aop = alu_op;
         if (PC_Write) psrc = pc_src;
         if (Reg_Write) wsel = wb_sel;
      end
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0; zero = 1'b0;
      tick(); tick();
      check("rst_state", state, 4'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_illegal", illegal, 1'b0);
      check("rst_enables", enables, 15'd0);

      rst = 1'b0;
      tick();
      check("idle_no_run", state, 4'd0);

      run = 1'b1;
      opcode = 7'b0110011;
      tick();
      check("fetch_state", state, 4'd1);
      check("fetch_ir_write", IR_Write, 1'b1);
      check("fetch_pc_write", PC_Write, 1'b1);

      // R ADD
      exec_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0);
      check("add_cycles", cyc, 4);
      check("add_rw_cycles", n_rw, 1);
      check("add_aluop", aop, 4'b0000);
      check("add_wbsel", wsel, 2'd0);
      check("add_next_fetch", state, 4'd1);
      check("add_instret", instret, 32'd1);

      // R SUB, I SRAI, I ADDI with func7[5]=1
      exec_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
      check("sub_aluop", aop, 4'b1000);
      exec_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0);
      check("srai_aluop", aop, 4'b1101);
      exec_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0);
      check("addi_aluop", aop, 4'b0000);
      check("addi_cycles", cyc, 4);
      check("alu_instret", instret, 32'd4);

      // Branches and JAL
      exec_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
      check("beq_cycles", cyc, 3);
      check("beq_taken", n_pcw, 1);
      check("beq_pcsrc", psrc, 2'd1);
      check("beq_aluop", aop, 4'b1000);
      exec_instr(7'b1100011, 3'b001, 7'b0000000, 1'b1);
      check("bne_cycles", cyc, 3);
      check("bne_not_taken", n_pcw, 0);
      exec_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0);
      check("bne_taken", n_pcw, 1);
      exec_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
      check("jal_cycles", cyc, 3);
      check("jal_rw", n_rw, 1);
      check("jal_wbsel", wsel, 2'd2);
      check("jal_pcsrc", psrc, 2'd2);
      check("jal_pcw", n_pcw, 1);
      check("br_instret", instret, 32'd8);

      // LUI
      exec_instr(7'b0110111, 3'b000, 7'b0000000, 1'b0);
      check("lui_cycles", cyc, 3);
      check("lui_wbsel", wsel, 2'd3);

      // Load then store
      exec_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
      check("load_cycles", cyc, 5);
      check("load_mem_read", n_mr, 2);
      check("load_wbsel", wsel, 2'd1);
      check("load_aluop", aop, 4'b0000);
      exec_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
      check("store_cycles", cyc, 4);
      check("store_mem_write", n_mw, 1);
      check("store_rw", n_rw, 0);
      check("ldst_instret", instret, 32'd11);

      // run dropped before retire: park in IDLE
      opcode = 7'b0110111;
      tick();
      run = 1'b0;
      tick();
      check("lui_wb_state", state, 4'd12);
      tick();
      check("retire_to_idle", state, 4'd0);
      check("idle_instret", instret, 32'd12);
      tick();
      check("idle_hold", state, 4'd0);
      run = 1'b1;
      tick();
      check("idle_to_fetch", state, 4'd1);

      // Asynchronous reset in MEM_RD
      opcode = 7'b0000011;
      tick(); tick(); tick();
      check("memrd_state", state, 4'd7);
      check("memrd_read", Mem_Read, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_state", state, 4'd0);
      check("async_rst_memread", Mem_Read, 1'b0);
      check("async_rst_instret", instret, 32'd0);
      #1;
      rst = 1'b0;
      tick();
      check("post_rst_fetch", state, 4'd1);

      // Illegal opcode: absorbing TRAP
      opcode = 7'b1110011;
      tick(); tick();
      check("trap_state", state, 4'd15);
      check("trap_illegal", illegal, 1'b1);
      check("trap_enables", enables, 15'd0);
      for (int i = 0; i < 10; i++) tick();
      check("trap_hold", state, 4'd15);
      check("trap_instret", instret, 32'd0);
      check("trap_sticky", illegal, 1'b1);

      // Branch with unsupported func3
      rst = 1'b1;
      #1;
      check("trap_cleared", illegal, 1'b0);
      rst = 1'b0;
      opcode = 7'b1100011; func3 = 3'b100;
      tick();
      check("br100_fetch", state, 4'd1);
      tick(); tick();
      check("br100_trap", state, 4'd15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
